// File: rtl/weight_loader.sv
// Weight loader: spreads one weight stream column-major across SYS_COLS FIFOs, with per-column credits.
// Define WEIGHT_LOADER_ERR_EN to add a sticky err output that flags a read strobe on an empty FIFO.
module weight_loader #(
    parameter int SYS_COLS     = 3,
    parameter int DWIDTH       = 8,
    parameter int ROWS_PER_COL = 3,
    parameter int FIFO_DEPTH   = 16,
    parameter int TILE_W       = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [TILE_W-1:0]   num_tiles,
    input  logic                s_valid,
    input  logic [DWIDTH-1:0]   s_data,
    output logic                s_ready,
    input  logic [SYS_COLS-1:0] rd_en,
    output logic [SYS_COLS-1:0] wr_en,
    output logic [DWIDTH-1:0]   wr_data,
    output logic                busy,
    output logic                done
`ifdef WEIGHT_LOADER_ERR_EN
    ,
    output logic                err
`endif
);
    localparam int CRW  = $clog2(FIFO_DEPTH + 1);
    localparam int COLW = (SYS_COLS > 1) ? $clog2(SYS_COLS) : 1;
    localparam int ROWW = (ROWS_PER_COL > 1) ? $clog2(ROWS_PER_COL) : 1;
    localparam logic [CRW-1:0]  CR_FULL  = CRW'(FIFO_DEPTH);
    localparam logic [COLW-1:0] COL_LAST = COLW'(SYS_COLS - 1);
    localparam logic [ROWW-1:0] ROW_LAST = ROWW'(ROWS_PER_COL - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

    state_t              state_q, state_d;
    logic [TILE_W-1:0]   tiles_q, tiles_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic [COLW-1:0]     col_q, col_d;
    logic [ROWW-1:0]     row_q, row_d;
    logic [CRW-1:0]      credit_q [SYS_COLS];
    logic [CRW-1:0]      credit_d [SYS_COLS];
    logic [SYS_COLS-1:0] wr_en_q, wr_en_d;
    logic [DWIDTH-1:0]   wr_data_q, wr_data_d;
    logic                hs;
    logic                last_word;

    assign hs        = s_valid & s_ready;
    assign last_word = (row_q == ROW_LAST) && (col_q == COL_LAST) &&
                       (tile_q == tiles_q - TILE_W'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            tiles_q   <= '0;
            tile_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < SYS_COLS; i++) credit_q[i] <= CR_FULL;
        end else begin
            state_q   <= state_d;
            tiles_q   <= tiles_d;
            tile_q    <= tile_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            for (int i = 0; i < SYS_COLS; i++) credit_q[i] <= credit_d[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        tiles_d   = tiles_q;
        tile_d    = tile_q;
        col_d     = col_q;
        row_d     = row_q;
        wr_en_d   = '0;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tiles_d = num_tiles;
                    tile_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = (num_tiles == '0) ? FIN : LOAD;
                end
            end
            LOAD: begin
                if (hs) begin
                    wr_en_d   = SYS_COLS'(1) << col_q;
                    wr_data_d = s_data;
                    if (row_q == ROW_LAST) begin
                        row_d = '0;
                        if (col_q == COL_LAST) begin
                            col_d  = '0;
                            tile_d = tile_q + TILE_W'(1);
                        end else begin
                            col_d = col_q + COLW'(1);
                        end
                    end else begin
                        row_d = row_q + ROWW'(1);
                    end
                    if (last_word) state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A write and a read on the same column cancel; reads of a full credit saturate.
        for (int i = 0; i < SYS_COLS; i++) begin
            credit_d[i] = credit_q[i];
            if (rd_en[i] && !(hs && col_q == COLW'(i))) begin
                if (credit_q[i] != CR_FULL) credit_d[i] = credit_q[i] + CRW'(1);
            end else if (!rd_en[i] && hs && col_q == COLW'(i)) begin
                credit_d[i] = credit_q[i] - CRW'(1);
            end
        end
    end

    // s_ready looks only at registered state so upstream can rely on it before asserting valid.
    always_comb begin
        s_ready = (state_q == LOAD) && (credit_q[col_q] != '0);
        busy    = (state_q != IDLE);
        done    = (state_q == FIN);
        wr_en   = wr_en_q;
        wr_data = wr_data_q;
    end

`ifdef WEIGHT_LOADER_ERR_EN
    logic                err_q;
    logic [SYS_COLS-1:0] empty_rd;

    always_comb begin
        empty_rd = '0;
        for (int i = 0; i < SYS_COLS; i++) empty_rd[i] = rd_en[i] && (credit_q[i] == CR_FULL);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          err_q <= 1'b0;
        else if (|empty_rd) err_q <= 1'b1;
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: a word-index/credit reference model predicts every cycle.
module tb_weight_loader;
    localparam int COLS = 3;
    localparam int DW   = 8;
    localparam int RPC  = 3;
    localparam int FD   = 4;
    localparam int TW   = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic            start = 1'b0;
    logic [TW-1:0]   num_tiles = '0;
    logic            s_valid = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic            s_ready;
    logic [COLS-1:0] rd_en = '0;
    logic [COLS-1:0] wr_en;
    logic [DW-1:0]   wr_data;
    logic            busy;
    logic            done;
`ifdef WEIGHT_LOADER_ERR_EN
    logic            err;
`endif

    weight_loader #(
        .SYS_COLS(COLS), .DWIDTH(DW), .ROWS_PER_COL(RPC), .FIFO_DEPTH(FD), .TILE_W(TW)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_tiles(num_tiles),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .rd_en(rd_en),
        .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .done(done)
`ifdef WEIGHT_LOADER_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: word k of a load goes to column (k / RPC) % COLS.
    typedef enum int {P_IDLE, P_LOAD, P_FIN} phase_t;
    typedef struct {
        int              cyc;
        logic [COLS-1:0] oh;
        logic [DW-1:0]   data;
    } wr_t;

    phase_t        m_phase = P_IDLE;
    int            m_total = 0;
    int            m_idx   = 0;
    int            m_credit [COLS];
    bit            m_hs    = 1'b0;
    logic [DW-1:0] m_wdata = '0;
    bit            m_err   = 1'b0;
    int            cyc     = 0;
    wr_t           sb_q [$];

    function automatic bit exp_ready();
        int col;
        col = (m_idx / RPC) % COLS;
        return (m_phase == P_LOAD) && (m_credit[col] > 0);
    endfunction

    always @(posedge clk or negedge rstn) begin : model
        int              col;
        bit              hs;
        int              d;
        logic [COLS-1:0] oh;
        if (!rstn) begin
            m_phase = P_IDLE;
            m_total = 0;
            m_idx   = 0;
            for (int i = 0; i < COLS; i++) m_credit[i] = FD;
            m_hs    = 1'b0;
            m_wdata = '0;
            m_err   = 1'b0;
            sb_q.delete();
        end else begin
            cyc++;
            col = (m_idx / RPC) % COLS;
            hs  = (m_phase == P_LOAD) && (m_credit[col] > 0) && s_valid;
            for (int i = 0; i < COLS; i++) begin
                if (rd_en[i] && m_credit[i] == FD) m_err = 1'b1;
                d = 0;
                if (rd_en[i]) d = d + 1;
                if (hs && col == i) d = d - 1;
                m_credit[i] = (m_credit[i] + d > FD) ? FD : m_credit[i] + d;
            end
            m_hs = hs;
            case (m_phase)
                P_IDLE: if (start) begin
                    m_total = int'(num_tiles);
                    m_idx   = 0;
                    m_phase = (m_total == 0) ? P_FIN : P_LOAD;
                end
                P_LOAD: if (hs) begin
                    oh      = '0;
                    oh[col] = 1'b1;
                    sb_q.push_back('{cyc, oh, s_data});
                    m_wdata = s_data;
                    m_idx++;
                    if (m_idx == m_total * RPC * COLS) m_phase = P_FIN;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin : monitor
        wr_t e;
        check("s_ready", 32'(s_ready), 32'(exp_ready()));
        check("busy", 32'(busy), 32'(m_phase != P_IDLE));
        check("done", 32'(done), 32'(m_phase == P_FIN));
        check("wr_data_hold", 32'(wr_data), 32'(m_wdata));
        if (sb_q.size() != 0 && sb_q[0].cyc == cyc) begin
            e = sb_q.pop_front();
            check("wr_en", 32'(wr_en), 32'(e.oh));
            check("wr_data", 32'(wr_data), 32'(e.data));
        end else begin
            check("wr_en_idle", 32'(wr_en), 32'd0);
        end
`ifdef WEIGHT_LOADER_ERR_EN
        check("err", 32'(err), 32'(m_err));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        num_tiles = TW'(n);
        step();
        start     = 1'b0;
    endtask

    task automatic drive_until_idle(input int budget, input int vld_pct, input int rd_pct, input bit seq);
        int            n   = 0;
        logic [DW-1:0] ctr = 1;
        while ((m_phase != P_IDLE || busy) && n < budget) begin
            s_valid = ($urandom_range(1, 100) <= vld_pct);
            s_data  = seq ? ctr : DW'($urandom);
            for (int i = 0; i < COLS; i++) rd_en[i] = ($urandom_range(1, 100) <= rd_pct);
            step();
            if (m_hs) ctr++;
            n++;
        end
        s_valid = 1'b0;
        rd_en   = '0;
        if (m_phase != P_IDLE || busy) begin
            n_vec++;
            n_fail++;
            $display("FAIL load_timeout: still busy after %0d cycles", budget);
        end
    endtask

    task automatic drain_credits();
        rd_en = '1;
        repeat (FD) step();
        rd_en = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        step();

        // Empty-FIFO read right after reset: saturates, and raises err when present.
        rd_en = 3'b100;
        step();
        rd_en = '0;
        repeat (2) step();

        // Basic load: one tile, words 1..9, valid held high, no reads.
        do_start(1);
        drive_until_idle(100, 100, 0, 1'b1);
        step();
        drain_credits();

        // Backpressure: two tiles with no reads stall on column 0 of the second tile.
        do_start(2);
        s_valid = 1'b1;
        for (int k = 0; k < 14; k++) begin
            s_data = DW'($urandom);
            step();
        end
        rd_en = 3'b010;
        step();
        rd_en = '0;
        repeat (3) step();
        rd_en = 3'b001;
        step();
        rd_en = '0;
        repeat (3) step();
        // Return one credit, then read and write column 0 in the same cycle.
        rd_en = 3'b001;
        step();
        rd_en = 3'b001;
        s_data = DW'($urandom);
        step();
        rd_en = '0;
        drive_until_idle(500, 100, 30, 1'b0);
        step();
        drain_credits();

        // Zero tiles: one busy cycle with done and no writes.
        do_start(0);
        repeat (3) step();

        // A second start during a load must not change the word count.
        do_start(1);
        s_valid = 1'b1;
        repeat (3) step();
        start     = 1'b1;
        num_tiles = TW'(7);
        step();
        start = 1'b0;
        drive_until_idle(500, 100, 25, 1'b1);
        step();

        // Randomized loads.
        for (int t = 0; t < 5; t++) begin
            drain_credits();
            do_start($urandom_range(1, 3));
            drive_until_idle(3000, 70, 35, 1'b0);
            repeat ($urandom_range(0, 3)) step();
        end
        drain_credits();

        // Asynchronous reset mid-load, after the fifth word.
        do_start(2);
        begin
            int n = 0;
            while (m_idx < 5 && n < 200) begin
                s_valid = 1'b1;
                s_data  = DW'($urandom);
                rd_en   = COLS'($urandom_range(0, 7));
                step();
                n++;
            end
        end
        rd_en = '0;
        #2;
        rstn = 1'b0;
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
`ifdef WEIGHT_LOADER_ERR_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        s_valid = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        step();
        do_start(1);
        drive_until_idle(500, 100, 40, 1'b1);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
